conclover_access_arbiter: RTL
=============================

# conclover_access_arbiter

Round-robin arbiter sharing the conclover byte-wide memory-access bus between NREQ requesters (kernel fetch, sample fetch, result writer). Sits between the conclover compute sequencers and the memory-access unit, which bridges byte operations onto Avalon-MM. Enforces one outstanding operation at a time, returns read data to the granted requester, and flags a timeout if the memory-access unit never answers.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- TIMEOUT, 1024, max cycles in WAIT before abort (≥4)
- CW, 11, timeout counter width; must satisfy 2^CW > TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset synchronous and active-high
- req_read  in  NREQ  per-requester read request, level, held until its req_rdy
- req_write  in  NREQ  per-requester write request, level; wins over req_read if both set
- req_addr  in  NREQ*16  relative byte address, slice i = [16i+15:16i]
- req_wdata  in  NREQ*8  write byte, slice i = [8i+7:8i]
- req_rdy  out  NREQ  one-cycle completion pulse to granted requester
- req_rdata  out  8  read byte, valid while req_rdy is nonzero, else 0
- mem_read, mem_write  out  1  one-cycle command pulse to memory-access unit
- mem_addr  out  16  relative address, valid with command pulse, else 0
- mem_wdata  out  8  write byte, valid with mem_write, else 0
- mem_rdy  in  1  completion pulse from memory-access unit
- mem_rdata  in  8  read byte, valid with mem_rdy
- grant  out  NREQ  one-hot current owner, 0 in IDLE
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: pending = req_read|req_write. If nonzero, pick first pending index at or after pointer ptr (wrap modulo NREQ); latch index, op (write if req_write[g]), addr, wdata; → ISSUE. Else stay.
- ISSUE: drive exactly one of mem_read/mem_write for one cycle with latched addr/wdata; clear timeout counter; → WAIT.
- WAIT: on mem_rdy, latch mem_rdata (writes: latch 0) → DONE. Counter increments each WAIT cycle; when counter == TIMEOUT-1 and no mem_rdy: set timeout_err, latch rdata=0 → DONE.
- DONE: req_rdy[g]=1, req_rdata=latched byte; ptr ← (g+1) mod NREQ; → IDLE. All requests ignored in DONE.
- Requester must drop its request in the cycle req_rdy is high; a request still high in the following IDLE is a new operation.
- mem_rdy outside WAIT is ignored.
- mem_rdy and timeout on same cycle: mem_rdy wins, no error.
- err_clr clears timeout_err; simultaneous set and clear: set wins.
- Requests changing while not in IDLE have no effect on the in-flight operation.

## Timing
- Reset: state IDLE, ptr=0, grant=0, all outputs 0, timeout_err=0, counter=0. Reset mid-operation aborts with no req_rdy; memory-access unit is reset on the same rst.
- Request seen in IDLE cycle t → command pulse at t+1 → WAIT from t+2 → mem_rdy at cycle k → req_rdy at k+1 → IDLE at k+2.
- Minimum turnaround (mem_rdy 2 cycles after command): request t, req_rdy t+4, next command no earlier than t+6.
- grant valid from ISSUE through DONE inclusive; busy likewise.
- All outputs registered or decoded from registered state; no combinational path req_* → mem_*.

## Structure
- Shared conclover package/header: state encodings, NREQ default, TIMEOUT default.
- Sub-module conclover_rr_pick: combinational, inputs pending[NREQ], ptr; outputs one-hot pick and index, valid. Instanced once in IDLE logic.

## Test plan
- Single read: req_read[1]=1, addr 0x0010; bench memory answers mem_rdy 2 cycles after pulse with 0xA5 → one mem_read, mem_addr=0x0010, req_rdy=3'b010 at t+4, req_rdata=0xA5.
- Fairness: all three requesters hold reads continuously from reset → grants in order 0,1,2,0,1,2; no requester served twice before others.
- Read+write same requester: req_read[0]=req_write[0]=1, wdata 0x3C → only mem_write pulses, mem_wdata=0x3C, req_rdata=0.
- Timeout: TIMEOUT=8, bench never returns mem_rdy → req_rdy pulses 8 cycles into WAIT, rdata 0, timeout_err=1 held until err_clr; arbiter then serves next request normally.
- Spurious mem_rdy in IDLE and ISSUE → no req_rdy, no state change; mem_rdy coincident with last timeout cycle → completion, timeout_err stays 0.
- Reset during WAIT → all outputs 0 next cycle, ptr=0, pending request re-issued afterward from index 0 rule.

Source files
------------

// File: rtl/conclover_access_arbiter_pkg.sv
// Shared definitions for the conclover memory-access arbiter: FSM encoding,
// default sizing and the round-robin wrap helper.
package conclover_access_arbiter_pkg;

  localparam int NREQ_DEFAULT    = 3;
  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int CW_DEFAULT      = 11;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // (base + off) mod n, for base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/conclover_rr_pick.sv
// Combinational round-robin selector: first pending index at or after the
// pointer, wrapping modulo NREQ.
module conclover_rr_pick
  import conclover_access_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_pending,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_cand;

  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'(rr_wrap(int'(i_ptr), k, NREQ));
      if (!o_valid && i_pending[w_cand]) begin
        o_valid        = 1'b1;
        o_idx          = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conclover_access_arbiter.sv
// Round-robin arbiter sharing the byte-wide memory-access bus between NREQ
// requesters, one outstanding operation at a time, with a WAIT timeout.
module conclover_access_arbiter
  import conclover_access_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = CW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_read,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_rdy,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_rdy,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int IW = $clog2(NREQ);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_idx;
  logic [NREQ-1:0]     r_grant;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CW-1:0]       r_cnt;
  logic                r_timeout_err;

  logic [NREQ-1:0]     w_pending;
  logic [NREQ-1:0]     w_pick;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_valid;
  logic                w_timeout_hit;

  assign w_pending     = req_read | req_write;
  // A real mem_rdy on the last WAIT cycle takes precedence over the timeout.
  assign w_timeout_hit = (r_state == ST_WAIT) && !mem_rdy && (r_cnt == CW'(TIMEOUT - 1));
  assign timeout_err   = r_timeout_err;

  conclover_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_pending (w_pending),
    .i_ptr     (r_ptr),
    .o_pick    (w_pick),
    .o_idx     (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_rdy      = '0;
    req_rdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    grant        = '0;
    busy         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy         = 1'b1;
        grant        = r_grant;
        mem_read     = !r_is_write;
        mem_write    = r_is_write;
        mem_addr     = r_addr;
        mem_wdata    = r_is_write ? r_wdata : '0;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy  = 1'b1;
        grant = r_grant;
        if (mem_rdy || w_timeout_hit) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        grant        = r_grant;
        req_rdy      = r_grant;
        req_rdata    = r_rdata;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operation context is captured once in IDLE; later request changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_idx      <= '0;
      r_grant    <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_idx      <= w_pick_idx;
            r_grant    <= w_pick;
            r_is_write <= req_write[w_pick_idx];
            r_addr     <= req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_wdata    <= req_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (mem_rdy)            r_rdata <= r_is_write ? '0 : mem_rdata;
          else if (w_timeout_hit) r_rdata <= '0;
        end
        ST_DONE: r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  // Sticky error: a timeout on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)                r_timeout_err <= 1'b0;
    else if (w_timeout_hit) r_timeout_err <= 1'b1;
    else if (err_clr)       r_timeout_err <= 1'b0;
  end

endmodule
